// File: rtl/disp_pkg.sv
// Shared constants and types for the multiplexed 7-segment display.
// Segment patterns are active-low, bit 0 = a ... bit 6 = g.
package disp_pkg;

  typedef logic [1:0] dig_idx_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  // Entry k is the pattern for digit k (k = 0 at the low end).
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
    7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef struct packed {
    logic [3:0][3:0] dig;
    logic            blank_lz;
    logic [3:0]      blink_mask;
    logic            colon_en;
  } shadow_t;

  localparam shadow_t SHADOW_CLR = '0;

  function automatic logic [3:0] an_sel(dig_idx_t i);
    return ~(4'b0001 << i);
  endfunction

endpackage

// File: rtl/seg_decoder.sv
// BCD to active-low 7-segment decode; codes 10..15 show a dash.
// Ports: bcd (4b in), seg (7b out, seg[0]=a .. seg[6]=g).
module seg_decoder
  import disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    unique case (bcd)
      4'd0:    seg = SEG_TABLE[0];
      4'd1:    seg = SEG_TABLE[1];
      4'd2:    seg = SEG_TABLE[2];
      4'd3:    seg = SEG_TABLE[3];
      4'd4:    seg = SEG_TABLE[4];
      4'd5:    seg = SEG_TABLE[5];
      4'd6:    seg = SEG_TABLE[6];
      4'd7:    seg = SEG_TABLE[7];
      4'd8:    seg = SEG_TABLE[8];
      4'd9:    seg = SEG_TABLE[9];
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/disp_scan_mux.sv
// 4-digit multiplexed 7-segment scanner with frame-latched inputs,
// leading-zero blanking, per-digit blink and colon dp.
// Ports: clk, rst (sync, active-low), d3..d0 BCD digits,
// blank_lz, blink_mask[3:0], colon_en; seg[6:0], an[3:0], dp
// (all outputs active-low and registered).
module disp_scan_mux
  import disp_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 125
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] d3,
  input  logic [3:0] d2,
  input  logic [3:0] d1,
  input  logic [3:0] d0,
  input  logic       blank_lz,
  input  logic [3:0] blink_mask,
  input  logic       colon_en,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp
);

  localparam int PRE_W = $clog2(REFRESH_DIV);
  localparam int BLK_W = $clog2(BLINK_DIV + 1);

  localparam logic [PRE_W-1:0] PRE_LAST =
    PRE_W'(REFRESH_DIV - 1);
  localparam logic [BLK_W-1:0] BLK_LAST =
    BLK_W'(BLINK_DIV - 1);

  logic [PRE_W-1:0] pre_cnt;
  logic [BLK_W-1:0] blk_cnt;
  dig_idx_t         idx;
  logic             phase;
  shadow_t          sh;

  logic             tick;
  logic             frame_end;
  logic             blk_wrap;
  shadow_t          sh_in;

  logic [3:0]       cur_dig;
  logic             blanked;
  logic [6:0]       dec_seg;
  logic [6:0]       seg_nxt;
  logic [3:0]       an_nxt;
  logic             dp_nxt;

  assign tick      = (pre_cnt == PRE_LAST);
  assign frame_end = tick && (idx == 2'd3);
  assign blk_wrap  = (blk_cnt == BLK_LAST);

  always_comb begin
    sh_in            = SHADOW_CLR;
    sh_in.dig        = {d3, d2, d1, d0};
    sh_in.blank_lz   = blank_lz;
    sh_in.blink_mask = blink_mask;
    sh_in.colon_en   = colon_en;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pre_cnt <= '0;
      idx     <= '0;
      blk_cnt <= '0;
      phase   <= 1'b0;
      sh      <= SHADOW_CLR;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + PRE_W'(1);
      if (tick) begin
        idx <= idx + 2'd1;
      end
      // Inputs are only sampled here so a frame never tears.
      if (frame_end) begin
        sh      <= sh_in;
        blk_cnt <= blk_wrap ? '0 : blk_cnt + BLK_W'(1);
        if (blk_wrap) begin
          phase <= ~phase;
        end
      end
    end
  end

  assign cur_dig = sh.dig[idx];

  seg_decoder u_dec (
    .bcd (cur_dig),
    .seg (dec_seg)
  );

  always_comb begin
    blanked = sh.blink_mask[idx] && phase;
    if (idx == 2'd3 && sh.blank_lz && sh.dig[3] == 4'd0) begin
      blanked = 1'b1;
    end
  end

  always_comb begin
    seg_nxt = SEG_BLANK;
    an_nxt  = 4'hF;
    dp_nxt  = 1'b1;
    if (!blanked) begin
      seg_nxt = dec_seg;
      an_nxt  = an_sel(idx);
      dp_nxt  = !(idx == 2'd2 && sh.colon_en);
    end
  end

  // Output stage lags the index register by one clock.
  always_ff @(posedge clk) begin
    if (!rst) begin
      seg <= SEG_BLANK;
      an  <= 4'hF;
      dp  <= 1'b1;
    end else begin
      seg <= seg_nxt;
      an  <= an_nxt;
      dp  <= dp_nxt;
    end
  end

endmodule

// File: tb/tb_disp_scan_mux.sv
// Randomised and directed bench for disp_scan_mux against a
// cycle-count based reference model.
module tb_disp_scan_mux;

  localparam int R = 4;
  localparam int B = 2;
  localparam int FR = 4 * R;

  localparam logic [6:0] PAT [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] d3, d2, d1, d0;
  logic       blank_lz;
  logic [3:0] blink_mask;
  logic       colon_en;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;

  always #5 clk = ~clk;

  disp_scan_mux #(
    .REFRESH_DIV (R),
    .BLINK_DIV   (B)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .d3         (d3),
    .d2         (d2),
    .d1         (d1),
    .d0         (d0),
    .blank_lz   (blank_lz),
    .blink_mask (blink_mask),
    .colon_en   (colon_en),
    .seg        (seg),
    .an         (an),
    .dp         (dp)
  );

  int checks   = 0;
  int failures = 0;

  // Model: n = clean edges since reset; shadows = last frame capture.
  int         n = 0;
  logic [3:0] s_d [4];
  logic       s_lz;
  logic [3:0] s_mask;
  logic       s_colon;

  logic [6:0] e_seg;
  logic [3:0] e_an;
  logic       e_dp;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s n=%0d got=%h exp=%h", tag, n, got, exp);
    end
  endtask

  function automatic logic [6:0] ref_seg(logic [3:0] v);
    if (v > 4'd9) return 7'h3F;
    return PAT[v];
  endfunction

  task automatic predict();
    int  i;
    int  frames;
    bit  ph;
    bit  blank;
    e_seg = 7'h7F;
    e_an  = 4'hF;
    e_dp  = 1'b1;
    if (rst) begin
      i      = (n / R) % 4;
      frames = n / FR;
      ph     = ((frames / B) % 2) == 1;
      blank  = (s_mask[i] && ph) ||
               (i == 3 && s_lz && s_d[3] == 4'd0);
      if (!blank) begin
        e_seg = ref_seg(s_d[i]);
        e_an  = 4'hF;
        e_an[i] = 1'b0;
        e_dp  = !(i == 2 && s_colon);
      end
    end
  endtask

  task automatic advance();
    if (!rst) begin
      n = 0;
      for (int k = 0; k < 4; k++) s_d[k] = 4'd0;
      s_lz = 0; s_mask = 0; s_colon = 0;
    end else begin
      n++;
      if (n % FR == 0) begin
        s_d[0] = d0; s_d[1] = d1; s_d[2] = d2; s_d[3] = d3;
        s_lz = blank_lz; s_mask = blink_mask;
        s_colon = colon_en;
      end
    end
  endtask

  task automatic step();
    predict();
    @(posedge clk);
    advance();
    @(negedge clk);
    chk("seg", 32'(seg), 32'(e_seg));
    chk("an", 32'(an), 32'(e_an));
    chk("dp", 32'(dp), 32'(e_dp));
    chk("an_onehot", 32'($countones(~an) <= 1), 32'd1);
  endtask

  task automatic run(int k);
    repeat (k) step();
  endtask

  task automatic to_idx(int i);
    int g = 0;
    while ((n / R) % 4 != i && g < 64) begin
      step();
      g++;
    end
    chk("to_idx_bound", 32'(g < 64), 32'd1);
  endtask

  initial begin
    rst = 0; d3 = 0; d2 = 0; d1 = 0; d0 = 0;
    blank_lz = 0; blink_mask = 0; colon_en = 0;
    for (int k = 0; k < 4; k++) s_d[k] = 4'd0;
    s_lz = 0; s_mask = 0; s_colon = 0;
    run(2);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_an", 32'(an), 32'hF);

    // Scan 1,2,3,4; cleared shadows show until first frame.
    rst = 1; d3 = 1; d2 = 2; d1 = 3; d0 = 4;
    step();
    chk("post_rst_d0", 32'(seg), 32'h40);
    chk("post_rst_an", 32'(an), 32'hE);
    run(3 * FR);

    // Leading zero blanking on and off.
    d3 = 0; blank_lz = 1;
    run(2 * FR);
    blank_lz = 0;
    run(2 * FR);

    // Blink digits 0,1 over several phases.
    d3 = 1; blink_mask = 4'b0011;
    run(6 * FR);
    blink_mask = 0;
    run(2 * FR);

    // Tearing: d0 changes mid-frame.
    d0 = 4;
    run(FR);
    to_idx(1);
    d0 = 9;
    run(2 * FR);

    // Colon and illegal code.
    colon_en = 1; d2 = 4'hC;
    run(2 * FR);

    // Reset mid-frame.
    to_idx(2);
    rst = 0;
    step();
    chk("mid_rst_an", 32'(an), 32'hF);
    chk("mid_rst_dp", 32'(dp), 32'd1);
    rst = 1;
    run(3 * FR);

    // Random traffic.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 7) == 0) begin
        d0 = 4'($urandom); d1 = 4'($urandom);
        d2 = 4'($urandom);
        d3 = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom);
        blank_lz = 1'($urandom);
        blink_mask = 4'($urandom);
        colon_en = 1'($urandom);
      end
      rst = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/disp_scan_mux.md
DISP_SCAN_MUX -- requirements
Module: disp_scan_mux

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, clk cycles per digit slot (1 kHz digit rate at 100 MHz); legal range >= 2.
REQ-002 SHALL have parameter BLINK_DIV, default 125, frames per blink-phase toggle (0.5 s at default); legal range >= 1.
REQ-003 SHALL have port clk  in  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-low.
REQ-005 SHALL have ports d3, d2, d1, d0  in  4 each  BCD digits; d3 = leftmost (hour tens), d0 = rightmost (minute units).
REQ-006 SHALL have port blank_lz  in  1  enables leading-zero blanking of d3.
REQ-007 SHALL have port blink_mask  in  4  bit i set = digit i blinks.
REQ-008 SHALL have port colon_en  in  1  lights the decimal point of digit 2 as the hour/minute separator.
REQ-009 SHALL have port seg  out  7  active-low segments; seg[0]=a … seg[6]=g.
REQ-010 SHALL have port an  out  4  active-low anodes; an[0] = d0 position.
REQ-011 SHALL have port dp  out  1  active-low decimal point.

Function
REQ-012 Prescaler SHALL count 0..REFRESH_DIV-1 and wrap; tick = 1 on the cycle the count equals REFRESH_DIV-1.
REQ-013 Digit index SHALL be 2 bits, advance by 1 on each tick, and wrap 3 -> 0.
REQ-014 Frame boundary = tick while index == 3; on that cycle shadow registers SHALL capture d3..d0, blank_lz, blink_mask and colon_en.
REQ-015 Input changes between frame boundaries SHALL NOT affect the outputs; no tearing within a frame.
REQ-016 Blink counter SHALL count frame boundaries 0..BLINK_DIV-1; at wrap, blink_phase SHALL toggle.
REQ-017 Digit i SHALL be blanked when (shadow blink_mask[i] AND blink_phase), or when (i == 3 AND shadow blank_lz AND shadow d3 == 0).
REQ-018 Non-blanked digit: an SHALL be one-hot low at the current index; seg SHALL be the decode of the shadow digit.
REQ-019 Blanked digit: an SHALL be 4'b1111, seg SHALL be 7'h7F, dp SHALL be 1.
REQ-020 Decode: 0..9 SHALL use standard patterns (e.g. 0 = 7'h40, 1 = 7'h79, 8 = 7'h00); 10..15 SHALL give dash 7'h3F (segment g only).
REQ-021 dp SHALL be 0 only when index == 2, shadow colon_en = 1 and digit 2 is not blanked; otherwise 1.
REQ-022 seg, an and dp SHALL be registered and SHALL reflect a new index exactly one clk after the index register changes.
REQ-023 At most one an bit SHALL be low in any cycle.

Reset
REQ-024 While rst = 0 at a clk edge: prescaler, index, blink counter, blink_phase and all shadows SHALL clear to 0; an SHALL be 4'hF, seg 7'h7F, dp 1.
REQ-025 Reset asserted mid-frame SHALL take effect on the next edge with no partial-frame completion.
REQ-026 After release, the display SHALL show the cleared shadows (digit 0 = "0"; d3 blanked only if blank_lz is captured) until the first frame boundary, 4*REFRESH_DIV cycles later.

Structure
REQ-027 Shared package disp_pkg SHALL hold the segment constants SEG_BLANK = 7'h7F and SEG_DASH = 7'h3F, the digit-pattern table, and the 2-bit digit-index type.
REQ-028 A combinational sub-module seg_decoder (4-bit in, 7-bit out) SHALL implement REQ-020; everything else stays in disp_scan_mux.

Verification (REFRESH_DIV=4, BLINK_DIV=2)
REQ-029 Scan: d3..d0 = 1,2,3,4, masks 0 -> an cycles 1110, 1101, 1011, 0111 every 4 clks; seg = 7'h19, 7'h30, 7'h24, 7'h79 respectively.
REQ-030 Leading zero: d3 = 0, blank_lz = 1 -> during index 3, an = 4'hF and seg = 7'h7F; with blank_lz = 0 -> an = 0111, seg = 7'h40.
REQ-031 Blink: blink_mask = 4'b0011 -> digits 0,1 dark for 2 frames and lit for 2 frames alternately; digits 2,3 always lit.
REQ-032 Tearing: change d0 from 4 to 9 during index 1 -> d0 still shows 7'h19 until the next frame boundary, then shows 7'h10.
REQ-033 Colon and illegal code: colon_en = 1, d2 = 4'hC -> during index 2, dp = 0 and seg = 7'h3F; dp = 1 at all other indices.
REQ-034 Reset mid-frame: rst = 0 at index 2 -> next edge an = 4'hF, seg = 7'h7F, dp = 1; after release the first tick occurs 4 clks later.
